mmc_cmd_ctrl: RTL and testbench
===============================

MMC_CMD_CTRL -- requirements
Module: mmc_cmd_ctrl

Interface
REQ-001 Parameter TIMEOUT_BITS, default 64, number of bit-clock rising edges allowed for response start (legal range 1..255).
REQ-002 clk_i  input  1  system clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset; synchronous, active-high.
REQ-004 bitclk_i  input  1  card bit clock, sampled in clk_i domain.
REQ-005 abort_i  input  1  cancel any command in progress.
REQ-006 cmd_valid_i  input  1  command request.
REQ-007 cmd_ready_o  output  1  controller can accept a command.
REQ-008 cmd_index_i  input  6  command index.
REQ-009 cmd_arg_i  input  32  command argument.
REQ-010 resp_type_i  input  2  0 = none, 1 = 48-bit, 2 = 136-bit, 3 = treated as 1.
REQ-011 ser_start_o / ser_abort_o  output  1 each  serialiser start / abort pulses.
REQ-012 ser_data_o  output  48  frame to serialiser.
REQ-013 ser_complete_i  input  1  serialiser finished frame (single-cycle pulse).
REQ-014 rx_start_o / rx_abort_o  output  1 each  response receiver start / abort pulses.
REQ-015 rx_long_o  output  1  expected response is 136-bit.
REQ-016 rx_busy_i  input  1  receiver has detected response start bit.
REQ-017 rx_complete_i  input  1  response received (pulse).
REQ-018 rx_crc_err_i  input  1  CRC error flag, valid with rx_complete_i.
REQ-019 busy_o / done_o / timeout_o / crc_err_o  output  1 each  busy, completion pulse, sticky status.

Function
REQ-020 The controller SHALL implement a state machine with states IDLE, TX, RX and FINISH; cmd_ready_o = (state == IDLE); busy_o = (state != IDLE).
REQ-021 In IDLE with cmd_valid_i=1 and abort_i=0, the controller SHALL latch index, arg and resp_type, clear timeout_o and crc_err_o, assert ser_start_o for exactly one cycle (the acceptance cycle), and enter TX.
REQ-022 ser_data_o SHALL equal {1'b0, 1'b1, index[5:0], arg[31:0], 7'b0, 1'b1}, registered at acceptance and held until the next acceptance.
REQ-023 rx_long_o SHALL be 1 iff the latched resp_type is 2, held with ser_data_o.
REQ-024 In TX, on ser_complete_i: if the latched resp_type is 0, go to FINISH; otherwise pulse rx_start_o for one cycle, clear the 8-bit timeout counter and enter RX.
REQ-025 Bit-clock rising edge SHALL be detected as bitclk_i & ~bitclk_q, where bitclk_q is a one-cycle delayed copy of bitclk_i.
REQ-026 In RX with rx_busy_i=0, each detected rising edge SHALL increment the timeout counter; with rx_busy_i=1 the counter SHALL hold.
REQ-027 In RX, when the counter equals TIMEOUT_BITS and rx_complete_i=0, the controller SHALL set timeout_o, pulse rx_abort_o for one cycle and go to FINISH.
REQ-028 In RX, on rx_complete_i, crc_err_o SHALL load rx_crc_err_i and the state SHALL go to FINISH; rx_complete_i has priority over a simultaneous timeout.
REQ-029 FINISH SHALL last exactly one cycle with done_o=1, then return to IDLE.
REQ-030 timeout_o and crc_err_o SHALL hold their values until the next acceptance or reset.
REQ-031 When abort_i=1 in TX, RX or FINISH, the controller SHALL:
- go to IDLE next cycle;
- pulse ser_abort_o and rx_abort_o for that one cycle;
- not pulse done_o;
- leave the status flags unchanged.
REQ-032 abort_i SHALL override ser_complete_i, rx_complete_i, timeout and cmd_valid_i in the same cycle.
REQ-033 abort_i in IDLE SHALL have no effect other than blocking acceptance.
REQ-034 cmd_valid_i outside IDLE SHALL be ignored, and the request SHALL not be queued.

Reset
REQ-035 On rst_i:
- state SHALL go to IDLE;
- the following SHALL be 0: bitclk_q, counter, ser_data_o, rx_long_o, timeout_o, crc_err_o, done_o, all pulse outputs;
- cmd_ready_o SHALL be 1.
REQ-036 Reset mid-command SHALL not generate abort pulses; the bench drives downstream reset.

Verification
REQ-037 CMD0, arg 0, resp 0:
- ser_data_o = 48'h400000000001;
- ser_start_o pulses once;
- after ser_complete_i, done_o pulses one cycle later;
- no rx_start_o.
REQ-038 CMD17, arg 32'h00001000, resp 1; rx_busy_i after 10 bit edges; rx_complete_i with crc_err=0:
- done_o=1;
- timeout_o=0, crc_err_o=0.
REQ-039 resp 1, TIMEOUT_BITS=64, rx_busy_i never asserted:
- on the 64th bit-clock rising edge, rx_abort_o pulses;
- timeout_o=1;
- done_o=1 next cycle.
REQ-040 CMD2, resp 2, rx_complete_i with rx_crc_err_i=1:
- rx_long_o=1;
- crc_err_o=1, held until the next accept.
REQ-041 abort_i together with ser_complete_i in TX:
- ser_abort_o=1 and rx_abort_o=1 for one cycle;
- state returns to IDLE;
- no done_o;
- cmd_ready_o=1 next cycle.
REQ-042 cmd_valid_i with abort_i in IDLE: no ser_start_o.
REQ-043 rx_complete_i on the same cycle the counter reaches TIMEOUT_BITS: timeout_o=0.

Source files
------------

// File: rtl/mmc_cmd_ctrl.sv
// MMC command-path controller.
// Accepts one command at a time, hands a 48-bit frame to the serialiser,
// optionally starts the response receiver, supervises the response-start
// timeout in card bit-clock edges, and reports done / timeout / CRC status.
// Start/abort/done strobes are combinational in the cycle the deciding
// condition is seen, so each one lines up with the cycle that causes it.
module mmc_cmd_ctrl #(
    parameter int TIMEOUT_BITS = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        bitclk_i,
    input  logic        abort_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [5:0]  cmd_index_i,
    input  logic [31:0] cmd_arg_i,
    input  logic [1:0]  resp_type_i,
    output logic        ser_start_o,
    output logic        ser_abort_o,
    output logic [47:0] ser_data_o,
    input  logic        ser_complete_i,
    output logic        rx_start_o,
    output logic        rx_abort_o,
    output logic        rx_long_o,
    input  logic        rx_busy_i,
    input  logic        rx_complete_i,
    input  logic        rx_crc_err_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        timeout_o,
    output logic        crc_err_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_TX     = 2'd1,
        S_RX     = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    // Timeout limit expressed at the counter width (legal limits fit in 8 bits).
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_BITS);

    state_t      state_q, state_d;
    logic        bitclk_q;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  rtype_q, rtype_d;
    logic [47:0] frame_q, frame_d;
    logic        long_q, long_d;
    logic        tmo_q, tmo_d;
    logic        crc_q, crc_d;

    logic        bit_rise;
    logic        ser_start_c;
    logic        ser_abort_c;
    logic        rx_start_c;
    logic        rx_abort_c;
    logic        done_c;

    // Rising edge of the card bit clock as seen in the system clock domain.
    assign bit_rise = bitclk_i & ~bitclk_q;

    // Next-state, datapath updates and strobe generation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rtype_d     = rtype_q;
        frame_d     = frame_q;
        long_d      = long_q;
        tmo_d       = tmo_q;
        crc_d       = crc_q;
        ser_start_c = 1'b0;
        ser_abort_c = 1'b0;
        rx_start_c  = 1'b0;
        rx_abort_c  = 1'b0;
        done_c      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // abort_i here only blocks acceptance.
                if (cmd_valid_i && !abort_i) begin
                    rtype_d     = resp_type_i;
                    frame_d     = {1'b0, 1'b1, cmd_index_i, cmd_arg_i, 7'b0, 1'b1};
                    long_d      = (resp_type_i == 2'd2);
                    tmo_d       = 1'b0;
                    crc_d       = 1'b0;
                    ser_start_c = 1'b1;
                    state_d     = S_TX;
                end
            end

            S_TX: begin
                if (abort_i) begin
                    ser_abort_c = 1'b1;
                    rx_abort_c  = 1'b1;
                    state_d     = S_IDLE;
                end else if (ser_complete_i) begin
                    if (rtype_q == 2'd0) begin
                        state_d = S_FINISH;
                    end else begin
                        rx_start_c = 1'b1;
                        cnt_d      = 8'd0;
                        state_d    = S_RX;
                    end
                end
            end

            S_RX: begin
                if (abort_i) begin
                    ser_abort_c = 1'b1;
                    rx_abort_c  = 1'b1;
                    state_d     = S_IDLE;
                end else if (rx_complete_i) begin
                    // A completed response wins over a coincident timeout.
                    crc_d   = rx_crc_err_i;
                    state_d = S_FINISH;
                end else if (cnt_q == TMO_LIMIT) begin
                    tmo_d      = 1'b1;
                    rx_abort_c = 1'b1;
                    state_d    = S_FINISH;
                end else if (bit_rise && !rx_busy_i) begin
                    // Count only while still waiting for the response start bit.
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
                if (abort_i) begin
                    ser_abort_c = 1'b1;
                    rx_abort_c  = 1'b1;
                end else begin
                    done_c = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Reset never produces strobes; downstream blocks are reset directly.
        if (rst_i) begin
            ser_start_c = 1'b0;
            ser_abort_c = 1'b0;
            rx_start_c  = 1'b0;
            rx_abort_c  = 1'b0;
            done_c      = 1'b0;
        end
    end

    // State, counter, frame and status registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            bitclk_q <= 1'b0;
            cnt_q    <= 8'd0;
            rtype_q  <= 2'd0;
            frame_q  <= 48'd0;
            long_q   <= 1'b0;
            tmo_q    <= 1'b0;
            crc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitclk_q <= bitclk_i;
            cnt_q    <= cnt_d;
            rtype_q  <= rtype_d;
            frame_q  <= frame_d;
            long_q   <= long_d;
            tmo_q    <= tmo_d;
            crc_q    <= crc_d;
        end
    end

    assign cmd_ready_o = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign ser_data_o  = frame_q;
    assign rx_long_o   = long_q;
    assign timeout_o   = tmo_q;
    assign crc_err_o   = crc_q;
    assign ser_start_o = ser_start_c;
    assign ser_abort_o = ser_abort_c;
    assign rx_start_o  = rx_start_c;
    assign rx_abort_o  = rx_abort_c;
    assign done_o      = done_c;

endmodule

// File: tb/tb_mmc_cmd_ctrl.sv
// Bench for mmc_cmd_ctrl: directed command sequences push expected strobe
// events into a queue; a monitor pops one entry for every cycle in which
// the DUT raises any strobe and compares strobes plus frame/status.
module tb_mmc_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        bitclk_i;
    logic        abort_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [5:0]  cmd_index_i;
    logic [31:0] cmd_arg_i;
    logic [1:0]  resp_type_i;
    logic        ser_start_o;
    logic        ser_abort_o;
    logic [47:0] ser_data_o;
    logic        ser_complete_i;
    logic        rx_start_o;
    logic        rx_abort_o;
    logic        rx_long_o;
    logic        rx_busy_i;
    logic        rx_complete_i;
    logic        rx_crc_err_i;
    logic        busy_o;
    logic        done_o;
    logic        timeout_o;
    logic        crc_err_o;

    mmc_cmd_ctrl #(.TIMEOUT_BITS(64)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .bitclk_i       (bitclk_i),
        .abort_i        (abort_i),
        .cmd_valid_i    (cmd_valid_i),
        .cmd_ready_o    (cmd_ready_o),
        .cmd_index_i    (cmd_index_i),
        .cmd_arg_i      (cmd_arg_i),
        .resp_type_i    (resp_type_i),
        .ser_start_o    (ser_start_o),
        .ser_abort_o    (ser_abort_o),
        .ser_data_o     (ser_data_o),
        .ser_complete_i (ser_complete_i),
        .rx_start_o     (rx_start_o),
        .rx_abort_o     (rx_abort_o),
        .rx_long_o      (rx_long_o),
        .rx_busy_i      (rx_busy_i),
        .rx_complete_i  (rx_complete_i),
        .rx_crc_err_i   (rx_crc_err_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .timeout_o      (timeout_o),
        .crc_err_o      (crc_err_o)
    );

    always #5 clk = ~clk;

    // Strobe order: {ser_start, ser_abort, rx_start, rx_abort, done}
    localparam logic [4:0] P_SS = 5'b10000;
    localparam logic [4:0] P_SA = 5'b01000;
    localparam logic [4:0] P_RS = 5'b00100;
    localparam logic [4:0] P_RA = 5'b00010;
    localparam logic [4:0] P_DN = 5'b00001;

    typedef struct packed {
        logic [4:0]  p;
        logic        chk;
        logic [47:0] d;
        logic        lng;
        logic        tmo;
        logic        crc;
    } ev_t;

    ev_t  exp_q[$];
    ev_t  mon_e;
    logic [4:0] mon_p;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Hand-computed frames {01, index, arg, 0000000, 1}
    localparam logic [47:0] F_CMD0      = 48'h400000000001;
    localparam logic [47:0] F_CMD17     = 48'h510000100001;
    localparam logic [47:0] F_CMD17_DB  = 48'h51DEADBEEF01;
    localparam logic [47:0] F_CMD2      = 48'h420000000001;
    localparam logic [47:0] F_CMD17_12  = 48'h511234567801;
    localparam logic [47:0] F_CMD0_A5   = 48'h40A5A5A5A501;
    localparam logic [47:0] F_CMD17_0   = 48'h510000000001;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] p, input logic chk, input logic [47:0] d,
                        input logic lng, input logic tmo, input logic crc);
        ev_t e;
        e.p = p; e.chk = chk; e.d = d; e.lng = lng; e.tmo = tmo; e.crc = crc;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt);
        cmd_valid_i = 1'b1;
        cmd_index_i = idx;
        cmd_arg_i   = arg;
        resp_type_i = rt;
        push(P_SS, 1'b0, 48'd0, 1'b0, 1'b0, 1'b0);
        step();
        cmd_valid_i = 1'b0;
    endtask

    task automatic bit_edges(input int n);
        for (int i = 0; i < n; i++) begin
            bitclk_i = 1'b1;
            step();
            bitclk_i = 1'b0;
            step();
        end
    endtask

    // Monitor: one queue entry per cycle with any strobe active.
    always @(negedge clk) begin
        mon_p = {ser_start_o, ser_abort_o, rx_start_o, rx_abort_o, done_o};
        if (mon_p != 5'b0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_strobe actual=%b required=none", mon_p);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_p !== mon_e.p ||
                    (mon_e.chk && ({ser_data_o, rx_long_o, timeout_o, crc_err_o} !==
                                   {mon_e.d, mon_e.lng, mon_e.tmo, mon_e.crc}))) begin
                    n_bad++;
                    $display("FAIL strobe_event actual=%b/%h/%b%b%b required=%b/%h/%b%b%b",
                             mon_p, ser_data_o, rx_long_o, timeout_o, crc_err_o,
                             mon_e.p, mon_e.d, mon_e.lng, mon_e.tmo, mon_e.crc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i = 1'b1; bitclk_i = 1'b0; abort_i = 1'b0; cmd_valid_i = 1'b0;
        cmd_index_i = 6'd0; cmd_arg_i = 32'd0; resp_type_i = 2'd0;
        ser_complete_i = 1'b0; rx_busy_i = 1'b0; rx_complete_i = 1'b0; rx_crc_err_i = 1'b0;
        step(); step(); step();

        // Reset state
        check("rst_ready", 64'(cmd_ready_o), 64'd1);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_status", 64'({ser_data_o, rx_long_o, timeout_o, crc_err_o, done_o}), 64'd0);
        rst_i = 1'b0;
        step();

        // CMD0, no response
        issue(6'd0, 32'd0, 2'd0);
        check("cmd0_frame", 64'(ser_data_o), 64'(F_CMD0));
        check("cmd0_busy", 64'({busy_o, cmd_ready_o}), 64'b10);
        step();
        ser_complete_i = 1'b1;
        push(P_DN, 1'b1, F_CMD0, 1'b0, 1'b0, 1'b0);
        step();
        ser_complete_i = 1'b0;
        step(); step();

        // CMD17, 48-bit response after 10 bit edges, good CRC; stray cmd_valid in RX
        issue(6'd17, 32'h00001000, 2'd1);
        check("cmd17_frame", 64'(ser_data_o), 64'(F_CMD17));
        ser_complete_i = 1'b1;
        push(P_RS, 1'b1, F_CMD17, 1'b0, 1'b0, 1'b0);
        step();
        ser_complete_i = 1'b0;
        cmd_valid_i = 1'b1; cmd_index_i = 6'd5; cmd_arg_i = 32'hFFFFFFFF;
        bit_edges(10);
        cmd_valid_i = 1'b0;
        rx_busy_i = 1'b1;
        bit_edges(60);
        rx_complete_i = 1'b1; rx_crc_err_i = 1'b0;
        push(P_DN, 1'b1, F_CMD17, 1'b0, 1'b0, 1'b0);
        step();
        rx_complete_i = 1'b0; rx_busy_i = 1'b0;
        step(); step();
        check("cmd17_status", 64'({timeout_o, crc_err_o, cmd_ready_o}), 64'b001);

        // Response timeout at 64 edges, resp_type 3 treated as 48-bit
        issue(6'd17, 32'hDEADBEEF, 2'd3);
        check("tmo_long", 64'(rx_long_o), 64'd0);
        ser_complete_i = 1'b1;
        push(P_RS, 1'b1, F_CMD17_DB, 1'b0, 1'b0, 1'b0);
        step();
        ser_complete_i = 1'b0;
        bit_edges(63);
        bitclk_i = 1'b1;
        push(P_RA, 1'b1, F_CMD17_DB, 1'b0, 1'b0, 1'b0);
        push(P_DN, 1'b1, F_CMD17_DB, 1'b0, 1'b1, 1'b0);
        step();
        bitclk_i = 1'b0;
        step(); step(); step();
        check("tmo_sticky", 64'({timeout_o, crc_err_o}), 64'b10);

        // CMD2, 136-bit response with CRC error
        issue(6'd2, 32'd0, 2'd2);
        check("cmd2_frame_long", 64'({ser_data_o, rx_long_o}), {15'd0, F_CMD2, 1'b1});
        check("accept_clears_tmo", 64'(timeout_o), 64'd0);
        ser_complete_i = 1'b1;
        push(P_RS, 1'b1, F_CMD2, 1'b1, 1'b0, 1'b0);
        step();
        ser_complete_i = 1'b0;
        bit_edges(2);
        rx_complete_i = 1'b1; rx_crc_err_i = 1'b1;
        push(P_DN, 1'b1, F_CMD2, 1'b1, 1'b0, 1'b1);
        step();
        rx_complete_i = 1'b0; rx_crc_err_i = 1'b0;
        step(); step(); step();
        check("crc_sticky", 64'({crc_err_o, rx_long_o}), 64'b11);

        // Abort together with ser_complete in TX
        issue(6'd17, 32'h12345678, 2'd1);
        check("accept_clears_crc", 64'(crc_err_o), 64'd0);
        step();
        abort_i = 1'b1; ser_complete_i = 1'b1;
        push(P_SA | P_RA, 1'b1, F_CMD17_12, 1'b0, 1'b0, 1'b0);
        step();
        abort_i = 1'b0; ser_complete_i = 1'b0;
        check("abort_tx_ready", 64'({cmd_ready_o, busy_o}), 64'b10);
        step();

        // cmd_valid with abort in IDLE: nothing accepted
        abort_i = 1'b1; cmd_valid_i = 1'b1; cmd_index_i = 6'd9; cmd_arg_i = 32'h1;
        step(); step();
        abort_i = 1'b0; cmd_valid_i = 1'b0;
        check("idle_abort_block", 64'({cmd_ready_o, ser_data_o}), {15'd0, 1'b1, F_CMD17_12});

        // rx_complete on the cycle the counter reaches the limit
        issue(6'd17, 32'h00001000, 2'd1);
        ser_complete_i = 1'b1;
        push(P_RS, 1'b1, F_CMD17, 1'b0, 1'b0, 1'b0);
        step();
        ser_complete_i = 1'b0;
        bit_edges(63);
        bitclk_i = 1'b1;
        step();
        bitclk_i = 1'b0;
        rx_complete_i = 1'b1; rx_crc_err_i = 1'b0;
        push(P_DN, 1'b1, F_CMD17, 1'b0, 1'b0, 1'b0);
        step();
        rx_complete_i = 1'b0;
        step(); step();
        check("race_no_timeout", 64'({timeout_o, cmd_ready_o}), 64'b01);

        // Abort in RX
        issue(6'd17, 32'h00001000, 2'd1);
        ser_complete_i = 1'b1;
        push(P_RS, 1'b1, F_CMD17, 1'b0, 1'b0, 1'b0);
        step();
        ser_complete_i = 1'b0;
        bit_edges(3);
        abort_i = 1'b1;
        push(P_SA | P_RA, 1'b1, F_CMD17, 1'b0, 1'b0, 1'b0);
        step();
        abort_i = 1'b0;
        check("abort_rx_ready", 64'(cmd_ready_o), 64'd1);
        step();

        // Abort in FINISH after a CRC error: no done, flag kept
        issue(6'd17, 32'd0, 2'd1);
        ser_complete_i = 1'b1;
        push(P_RS, 1'b1, F_CMD17_0, 1'b0, 1'b0, 1'b0);
        step();
        ser_complete_i = 1'b0;
        rx_complete_i = 1'b1; rx_crc_err_i = 1'b1;
        step();
        rx_complete_i = 1'b0; rx_crc_err_i = 1'b0;
        abort_i = 1'b1;
        push(P_SA | P_RA, 1'b1, F_CMD17_0, 1'b0, 1'b0, 1'b1);
        step();
        abort_i = 1'b0;
        check("abort_fin_flag", 64'({crc_err_o, cmd_ready_o}), 64'b11);
        step();

        // Abort in FINISH for a no-response command
        issue(6'd0, 32'hA5A5A5A5, 2'd0);
        ser_complete_i = 1'b1;
        step();
        ser_complete_i = 1'b0;
        abort_i = 1'b1;
        push(P_SA | P_RA, 1'b1, F_CMD0_A5, 1'b0, 1'b0, 1'b0);
        step();
        abort_i = 1'b0;
        step();

        // Reset mid-command: no strobes, registers cleared
        issue(6'd17, 32'h1, 2'd1);
        rst_i = 1'b1;
        step(); step();
        check("midrst_state", 64'({cmd_ready_o, busy_o, ser_data_o, timeout_o, crc_err_o}),
              64'({1'b1, 1'b0, 48'd0, 1'b0, 1'b0}));
        rst_i = 1'b0;
        step(); step(); step();

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
